// File: rtl/serial_adder.sv
// serial_adder: bit-serial LSB-first adder built from half-adder cells and a carry flip-flop

// serial_adder_ha: half-adder cell
module serial_adder_ha (
    input  logic i_x,
    input  logic i_y,
    output logic o_s,
    output logic o_c
);
    assign o_s = i_x ^ i_y;
    assign o_c = i_x & i_y;
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-2:0] r_res;
    logic             r_c;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             w_s1;
    logic             w_c1;
    logic             w_s;
    logic             w_c2;
    logic             w_c;
    logic             w_accept;
    logic             w_last;
    logic [WIDTH-1:0] w_shift;

    serial_adder_ha u_ha0 (.i_x(r_a[0]), .i_y(r_b[0]), .o_s(w_s1), .o_c(w_c1));
    serial_adder_ha u_ha1 (.i_x(w_s1),   .i_y(r_c),    .o_s(w_s),  .o_c(w_c2));

    assign w_c     = w_c1 | w_c2;
    assign w_shift = {w_s, r_res};
    assign busy    = (r_state == S_ADD);
    assign done    = (r_state == S_DONE);
    assign sum     = r_sum;
    assign cout    = r_cout;

    // Next state: start is honoured outside ADD; stray encodings fall back to IDLE
    always_comb begin
        w_accept    = start && (r_state != S_ADD);
        w_last      = (r_state == S_ADD) && (r_cnt == LAST);
        w_state_nxt = w_accept ? S_ADD : w_last ? S_DONE : (r_state != S_ADD) ? S_IDLE : r_state;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Datapath: capture operands, shift one bit per cycle, publish result on the last bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a    <= '0;
            r_b    <= '0;
            r_res  <= '0;
            r_c    <= 1'b0;
            r_cnt  <= '0;
            r_sum  <= '0;
            r_cout <= 1'b0;
        end else if (w_accept) begin
            r_a   <= a;
            r_b   <= b;
            r_c   <= 1'b0;
            r_cnt <= '0;
        end else if (r_state == S_ADD) begin
            r_a   <= r_a >> 1;
            r_b   <= r_b >> 1;
            r_res <= w_shift[WIDTH-1:1];
            r_c   <= w_c;
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
            if (w_last) begin
                r_sum  <= w_shift;
                r_cout <= w_c;
            end
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed checks of serial_adder at WIDTH=8 plus exhaustive WIDTH=4
module tb_serial_adder;
    logic       clk;
    logic       rst_n;
    logic       start8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       busy8;
    logic       done8;
    logic [7:0] sum8;
    logic       cout8;
    logic       start4;
    logic [3:0] a4;
    logic [3:0] b4;
    logic       busy4;
    logic       done4;
    logic [3:0] sum4;
    logic       cout4;
    int         tests;
    int         fails;
    logic [7:0] last_sum;
    logic       last_cout;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge while dut8 is IDLE or DONE
    task automatic run8(input string tag, input logic [7:0] a_v, input logic [7:0] b_v,
                        input logic [7:0] exp_s, input logic exp_c);
        int n;
        int bc;
        a8 = a_v;
        b8 = b_v;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        bc = busy8 ? 1 : 0;
        chk({tag, "_hold_sum"}, 32'(sum8), 32'(last_sum));
        chk({tag, "_hold_cout"}, 32'(cout8), 32'(last_cout));
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (busy8) bc++;
        end while (!done8 && n < 20);
        chk({tag, "_latency"}, 32'(n), 32'd8);
        chk({tag, "_busy_cycles"}, 32'(bc), 32'd8);
        chk({tag, "_sum"}, 32'(sum8), 32'(exp_s));
        chk({tag, "_cout"}, 32'(cout8), 32'(exp_c));
        last_sum  = exp_s;
        last_cout = exp_c;
    endtask

    initial begin
        int n;
        int dn;
        tests     = 0;
        fails     = 0;
        last_sum  = 8'd0;
        last_cout = 1'b0;
        rst_n  = 1'b0;
        start8 = 1'b0;
        a8     = 8'd0;
        b8     = 8'd0;
        start4 = 1'b0;
        a4     = 4'd0;
        b4     = 4'd0;
        #1;
        chk("rst_busy", 32'(busy8), 32'd0);
        chk("rst_done", 32'(done8), 32'd0);
        chk("rst_sum", 32'(sum8), 32'd0);
        chk("rst_cout", 32'(cout8), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", 32'(busy8), 32'd0);
        chk("idle_done", 32'(done8), 32'd0);

        // Test 1: 3+5, then result holds
        run8("t1", 8'd3, 8'd5, 8'd8, 1'b0);
        @(negedge clk);
        chk("t1_done_once", 32'(done8), 32'd0);
        chk("t1_after_sum", 32'(sum8), 32'd8);
        chk("t1_after_cout", 32'(cout8), 32'd0);

        // Test 2: overflow and patterns
        run8("t2a", 8'd255, 8'd1, 8'd0, 1'b1);
        run8("t2b", 8'd170, 8'd85, 8'd255, 1'b0);
        run8("t2c", 8'd0, 8'd0, 8'd0, 1'b0);
        @(negedge clk);

        // Test 3: start during ADD is ignored
        a8 = 8'd10;
        b8 = 8'd20;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        start8 = 1'b1;
        a8 = 8'd1;
        b8 = 8'd1;
        @(negedge clk);
        start8 = 1'b0;
        a8 = 8'd0;
        b8 = 8'd0;
        dn = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (done8) begin
                dn++;
                chk("t3_sum_at_done", 32'(sum8), 32'd30);
            end
        end
        chk("t3_done_count", 32'(dn), 32'd1);
        chk("t3_sum_hold", 32'(sum8), 32'd30);

        // Test 4: asynchronous reset mid-ADD
        a8 = 8'd200;
        b8 = 8'd100;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        chk("t4_busy_before", 32'(busy8), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t4_rst_busy", 32'(busy8), 32'd0);
        chk("t4_rst_done", 32'(done8), 32'd0);
        chk("t4_rst_sum", 32'(sum8), 32'd0);
        chk("t4_rst_cout", 32'(cout8), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dn = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done8) dn++;
        end
        chk("t4_no_done", 32'(dn), 32'd0);
        last_sum  = 8'd0;
        last_cout = 1'b0;
        run8("t4b", 8'd7, 8'd9, 8'd16, 1'b0);

        // Test 5: start held high, back-to-back operations
        @(negedge clk);
        a8 = 8'd100;
        b8 = 8'd27;
        start8 = 1'b1;
        @(negedge clk);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done8 && n < 20);
        chk("t5a_latency", 32'(n), 32'd8);
        chk("t5a_sum", 32'(sum8), 32'd127);
        chk("t5a_cout", 32'(cout8), 32'd0);
        a8 = 8'd128;
        b8 = 8'd128;
        @(negedge clk);
        chk("t5b_no_gap_busy", 32'(busy8), 32'd1);
        chk("t5b_done_once", 32'(done8), 32'd0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done8 && n < 20);
        start8 = 1'b0;
        chk("t5b_latency", 32'(n), 32'd8);
        chk("t5b_sum", 32'(sum8), 32'd0);
        chk("t5b_cout", 32'(cout8), 32'd1);
        @(negedge clk);
        chk("t5b_idle_done", 32'(done8), 32'd0);
        chk("t5b_idle_busy", 32'(busy8), 32'd0);

        // Test 6: exhaustive WIDTH=4, issued back-to-back from each DONE cycle
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                a4 = 4'(i);
                b4 = 4'(j);
                start4 = 1'b1;
                @(negedge clk);
                start4 = 1'b0;
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!done4 && n < 12);
                chk($sformatf("w4_lat a=%0d b=%0d", i, j), 32'(n), 32'd4);
                chk($sformatf("w4_sum a=%0d b=%0d", i, j), 32'({cout4, sum4}), 32'(i + j));
            end
        end
        @(negedge clk);
        chk("w4_idle_busy", 32'(busy4), 32'd0);
        chk("w4_idle_done", 32'(done4), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial N-bit adder that adds LSB-first, one bit per clock, through a full-adder cell built from two half-adder cells and a carry flip-flop.
- It sits directly downstream of the half-adder cell and is the first sequential arithmetic stage built on it.
- It accepts two operands with a start pulse, iterates WIDTH cycles, then presents a registered sum, carry-out and a one-cycle done strobe.

Parameters:
WIDTH, 8, operand and sum width in bits (legal range 2..32)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  begin addition; sampled only in IDLE or DONE
a  input  WIDTH  operand A, captured on the accepted start edge
b  input  WIDTH  operand B, captured on the accepted start edge
busy  output  1  high while an addition is in progress
done  output  1  one-cycle strobe, high when sum/cout become valid
sum  output  WIDTH  registered result (a+b) mod 2^WIDTH
cout  output  1  registered carry-out of the MSB

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; busy=0, done=0, sum=0, cout=0.
  - Internal shift registers, carry flip-flop and bit counter are cleared.
  - Reset asserted mid-operation aborts the addition; no done is produced.
- States:
  - IDLE: start=1 at a rising edge captures a and b into shift registers, clears carry and counter, and moves to ADD.
  - ADD: each edge computes s_bit = a_sh[0]^b_sh[0]^c and c_next = majority(a_sh[0], b_sh[0], c).
    - s_bit comes from the half-adder pair; c is the OR of the two half-adder carries.
    - a_sh and b_sh shift right. The result shift register shifts right with s_bit inserted at the MSB. Carry is updated and the counter increments.
    - At the edge where the counter reaches WIDTH-1, the full result is copied to sum and the final carry to cout, and the block moves to DONE.
  - DONE: lasts one cycle. start=1 behaves exactly as in IDLE (back-to-back operation, no idle gap); otherwise the block moves to IDLE.
- Outputs:
  - busy=1 exactly in ADD; done=1 exactly in DONE.
  - sum and cout change only at the completion edge. They hold their value through IDLE and through any following ADD until the next completion.
- Latency:
  - start accepted at edge E0; ADD spans edges E1..EWIDTH.
  - done is high in the cycle following edge EWIDTH, which is WIDTH cycles after E0 as seen at the outputs.
  - Throughput is one result per WIDTH+1 cycles with back-to-back starts.
- Boundary conditions:
  - start while busy=1 is ignored, and a/b changes in ADD have no effect.
  - Overflow wraps modulo 2^WIDTH, with the lost bit reported on cout.
  - The counter width is clog2(WIDTH); it never exceeds WIDTH-1.
  - No X may reach outputs after reset deassertion.

Test Plan:
1. WIDTH=8, a=3, b=5, single start pulse -> busy high 8 cycles, done one cycle, sum=8, cout=0; sum/cout hold afterwards.
2. a=255, b=1 -> sum=0, cout=1; a=170, b=85 -> sum=255, cout=0; a=0, b=0 -> sum=0, cout=0.
3. Start a=10, b=20, then pulse start with a=1, b=1 during cycle 3 of ADD -> second start ignored, done once, sum=30.
4. Start a=200, b=100, deassert rst_n at ADD cycle 4 for one cycle -> busy, done, sum and cout go to 0 immediately (asynchronously). No done appears afterwards. A fresh start a=7, b=9 gives sum=16.
5. Hold start high continuously with a=100, b=27 then a=128, b=128 changed in the DONE cycle -> first done with sum=127, cout=0. The immediately following operation gives sum=0, cout=1, with one done per operation.
6. Exhaustive check at WIDTH=4: all 256 (a,b) pairs -> {cout,sum} equals a+b for every pair, and done latency is exactly 4 cycles every time.
